// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Merges NUM_CH core-side pulse-protocol request/response channels onto one
// downstream memory port. Each channel owns a single pending-request slot.
// Slots are granted in fixed-priority (lowest index first) or round-robin
// order. Exactly one downstream transaction is in flight at any time. An
// optional response timeout turns a silent downstream into an error response.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   req_enable_i    per-channel request pulse
//   req_mode_i      per-channel mode (1 = write, 0 = read)
//   req_addr_i      flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata_i     flattened write data
//   req_wstrb_i     flattened byte strobes
//   resp_enable_o   per-channel response pulse
//   resp_data_o     response data, held until the next response
//   resp_err_o      response is a timeout error, held like resp_data_o
//   mreq_enable_o   downstream request pulse
//   mreq_mode_o     downstream mode
//   mreq_addr_o     downstream address
//   mreq_wdata_o    downstream write data
//   mreq_wstrb_o    downstream byte strobes
//   mresp_enable_i  downstream response pulse
//   mresp_data_i    downstream response data
//   proto_err_o     sticky; a channel requested while still outstanding
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0]             req_enable_i,
    input  logic [NUM_CH-1:0]             req_mode_i,
    input  logic [NUM_CH*ADDR_W-1:0]      req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]      req_wdata_i,
    input  logic [NUM_CH*(DATA_W/8)-1:0]  req_wstrb_i,
    output logic [NUM_CH-1:0]             resp_enable_o,
    output logic [DATA_W-1:0]             resp_data_o,
    output logic                          resp_err_o,
    output logic                          mreq_enable_o,
    output logic                          mreq_mode_o,
    output logic [ADDR_W-1:0]             mreq_addr_o,
    output logic [DATA_W-1:0]             mreq_wdata_o,
    output logic [DATA_W/8-1:0]           mreq_wstrb_o,
    input  logic                          mresp_enable_i,
    input  logic [DATA_W-1:0]             mresp_data_i,
    output logic                          proto_err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CH-1:0]      pendV_q, pendV_d;
    logic [NUM_CH-1:0]      capture;
    logic                   protoHit;
    logic [NUM_CH-1:0]      slotMode_q;
    logic [ADDR_W-1:0]      slotAddr_q  [NUM_CH];
    logic [DATA_W-1:0]      slotWdata_q [NUM_CH];
    logic [STRB_W-1:0]      slotWstrb_q [NUM_CH];
    logic [CH_W-1:0]        cur_q;
    logic [CH_W-1:0]        rrPtr_q;
    logic [CH_W-1:0]        grant;
    logic                   anyPend;
    int                     arbStart;
    logic [CNT_W-1:0]       waitCnt_q;
    logic                   timeoutHit;
    logic [DATA_W-1:0]      rdata_q;
    logic                   rerr_q;
    logic                   mreqEnable_q;
    logic                   mreqMode_q;
    logic [ADDR_W-1:0]      mreqAddr_q;
    logic [DATA_W-1:0]      mreqWdata_q;
    logic [STRB_W-1:0]      mreqWstrb_q;
    logic [NUM_CH-1:0]      respEnable_q;
    logic [DATA_W-1:0]      respData_q;
    logic                   respErr_q;
    logic                   protoErr_q;

    // Winner selection over the slots that were valid at the start of the
    // cycle. Round-robin starts one past the last served channel and wraps;
    // fixed priority always starts at channel 0.
    always_comb begin
        grant    = '0;
        anyPend  = 1'b0;
        arbStart = (RR_MODE != 0) ? ((int'(rrPtr_q) + 1) % NUM_CH) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!anyPend && pendV_q[(arbStart + k) % NUM_CH]) begin
                anyPend = 1'b1;
                grant   = CH_W'((arbStart + k) % NUM_CH);
            end
        end
    end

    // Slot bookkeeping: the issued slot frees up in ISSUE, and a new request
    // is accepted only if its channel has nothing pending and nothing in
    // flight. Anything else is a protocol violation and is dropped.
    always_comb begin
        pendV_d  = pendV_q;
        capture  = '0;
        protoHit = 1'b0;
        if (state_q == ISSUE) begin
            pendV_d[cur_q] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_enable_i[i]) begin
                if (pendV_q[i] ||
                    (((state_q == WAIT) || (state_q == RESP)) && (cur_q == CH_W'(i)))) begin
                    protoHit = 1'b1;
                end else begin
                    capture[i] = 1'b1;
                    pendV_d[i] = 1'b1;
                end
            end
        end
    end

    // A downstream response in the same cycle as expiry takes precedence.
    assign timeoutHit = (TIMEOUT > 0) && (waitCnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state logic for the single-transaction downstream sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyPend) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mresp_enable_i || timeoutHit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-channel request payload storage, written only on acceptance.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture[i]) begin
                slotMode_q[i]  <= req_mode_i[i];
                slotAddr_q[i]  <= req_addr_i[i*ADDR_W +: ADDR_W];
                slotWdata_q[i] <= req_wdata_i[i*DATA_W +: DATA_W];
                slotWstrb_q[i] <= req_wstrb_i[i*STRB_W +: STRB_W];
            end
        end
    end

    // Control and output registers. The downstream fields are loaded when
    // leaving IDLE so they are already stable during the ISSUE pulse and
    // stay put until the next grant. The response is registered once more
    // in RESP, which gives the two-cycle response latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pendV_q      <= '0;
            cur_q        <= '0;
            rrPtr_q      <= CH_W'(NUM_CH - 1);
            waitCnt_q    <= '0;
            rdata_q      <= '0;
            rerr_q       <= 1'b0;
            mreqEnable_q <= 1'b0;
            mreqMode_q   <= 1'b0;
            mreqAddr_q   <= '0;
            mreqWdata_q  <= '0;
            mreqWstrb_q  <= '0;
            respEnable_q <= '0;
            respData_q   <= '0;
            respErr_q    <= 1'b0;
            protoErr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pendV_q      <= pendV_d;
            protoErr_q   <= protoErr_q | protoHit;
            mreqEnable_q <= 1'b0;
            respEnable_q <= '0;
            case (state_q)
                IDLE: begin
                    if (anyPend) begin
                        mreqEnable_q <= 1'b1;
                        cur_q        <= grant;
                        mreqMode_q   <= slotMode_q[grant];
                        mreqAddr_q   <= slotAddr_q[grant];
                        mreqWdata_q  <= slotWdata_q[grant];
                        mreqWstrb_q  <= slotWstrb_q[grant];
                    end
                end
                ISSUE: begin
                    waitCnt_q <= '0;
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q + 1'b1;
                    if (mresp_enable_i) begin
                        rdata_q <= mresp_data_i;
                        rerr_q  <= 1'b0;
                    end else if (timeoutHit) begin
                        rdata_q <= '0;
                        rerr_q  <= 1'b1;
                    end
                end
                RESP: begin
                    respEnable_q[cur_q] <= 1'b1;
                    respData_q          <= rdata_q;
                    respErr_q           <= rerr_q;
                    rrPtr_q             <= cur_q;
                end
                default: ;
            endcase
        end
    end

    assign resp_enable_o = respEnable_q;
    assign resp_data_o   = respData_q;
    assign resp_err_o    = respErr_q;
    assign mreq_enable_o = mreqEnable_q;
    assign mreq_mode_o   = mreqMode_q;
    assign mreq_addr_o   = mreqAddr_q;
    assign mreq_wdata_o  = mreqWdata_q;
    assign mreq_wstrb_o  = mreqWstrb_q;
    assign proto_err_o   = protoErr_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Merges NUM_CH independent core-side request/response channels (fetch, mem, page-table walker, ...) onto one downstream memory port.
- Every channel uses the same pulse protocol as the core's fetch/mem buses: a request_enable pulse with mode/addr/wdata/wstrb, answered later by a response_enable pulse with data.
- Buffers one pending request per channel and arbitrates in fixed-priority or round-robin mode.
- Keeps one downstream transaction in flight, with an optional response timeout.

Parameters:
- NUM_CH, 2, number of upstream channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 0, cycles in WAIT before forced error response; 0 = disabled

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_enable  in  NUM_CH  per-channel request pulse
- req_mode  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH*ADDR_W  flattened, channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  flattened write data
- req_wstrb  in  NUM_CH*DATA_W/8  flattened byte strobes
- resp_enable  out  NUM_CH  per-channel response pulse
- resp_data  out  DATA_W  response data, valid with any resp_enable bit
- resp_err  out  1  high with resp_enable when the response is a timeout
- mreq_enable  out  1  downstream request pulse
- mreq_mode  out  1  downstream mode
- mreq_addr  out  ADDR_W  downstream address
- mreq_wdata  out  DATA_W  downstream write data
- mreq_wstrb  out  DATA_W/8  downstream strobes
- mresp_enable  in  1  downstream response pulse
- mresp_data  in  DATA_W  downstream response data
- proto_err  out  1  sticky; set when a channel requests while its previous request is still unanswered

Behaviour:
- Reset values: all outputs 0; all pending valid bits 0; FSM in IDLE; round-robin pointer = NUM_CH-1, so channel 0 is searched first.
- Upstream capture:
  - req_enable[i] high with pend_v[i]=0 latches mode/addr/wdata/wstrb into slot i and sets pend_v[i].
  - req_enable[i] high with pend_v[i]=1 (or channel i in flight) drops the request and sets proto_err.
- Channel reuse: a channel may issue a new request in the same cycle its resp_enable bit is high; the slot is free by then.
- FSM states:
  - IDLE: if any pend_v is set, pick winner g and go to ISSUE. Arbitration sees only slots valid at cycle start; same-cycle captures compete next cycle.
  - ISSUE: assert mreq_enable for exactly 1 cycle with slot g's fields; clear pend_v[g]; record cur=g; go to WAIT.
  - WAIT: on mresp_enable, register mresp_data and go to RESP. With TIMEOUT>0, a counter reset on entry to WAIT reaching TIMEOUT goes to RESP with data 0 and err=1.
  - RESP: resp_enable[cur]=1 for 1 cycle, plus resp_data and resp_err; update round-robin pointer to cur; go to IDLE.
- Arbitration:
  - Fixed priority (RR_MODE=0): lowest valid index wins.
  - Round-robin (RR_MODE=1): search starts at pointer+1 mod NUM_CH and wraps.
- Latency: request at cycle t, idle arbiter → mreq_enable at t+2. mresp_enable at cycle r → resp_enable at r+2. Back-to-back grants are 4 cycles apart minimum.
- mreq_* fields are held stable from ISSUE until the next ISSUE; the downstream samples only on the pulse.
- mresp_enable in IDLE, ISSUE or RESP is ignored.
- mresp_enable in the same cycle the timeout expires: the real response wins, err=0.
- resp_data and resp_err hold their value until the next RESP.
- rst mid-transaction:
  - Pending slots and in-flight state are discarded; no response is delivered.
  - A downstream response arriving after reset is ignored because the FSM is in IDLE.
  - proto_err clears only on rst.
- NUM_CH=1 degenerates to a pass-through with the same 2-cycle registered latency.

Test Plan:
- NUM_CH=2, RR_MODE=0: single read on ch1 at t=0, addr 0x8000_0010; downstream answers 0xDEAD_BEEF 3 cycles after the pulse → mreq_enable at t=2 with addr 0x8000_0010, resp_enable=2'b10 and resp_data=0xDEAD_BEEF at t=7.
- RR_MODE=0: ch0 and ch1 request in the same cycle → ch0 issued first; ch1 issued after ch0's RESP; ch0 requesting again during ch1's WAIT is served next.
- RR_MODE=1, NUM_CH=3: all channels request continuously, reissuing on each response → grant order 0,1,2,0,1,2, with the pointer wrapping from 2 to 0.
- Write on ch0 with mode=1, wstrb=4'b0011, wdata=0x1234_5678 → mreq_mode=1, mreq_wstrb=4'b0011, mreq_wdata=0x1234_5678; the response pulse is delivered to ch0.
- TIMEOUT=8, downstream never answers → resp_enable[cur] with resp_err=1 and resp_data=0 on the 9th cycle after entering WAIT. A late mresp_enable afterwards is ignored and the next grant proceeds normally.
- ch1 pulses twice before any response → proto_err=1 and stays 1; the second request is not issued. rst asserted during WAIT → all outputs 0, no resp_enable after reset, and proto_err cleared.
